// File: rtl/heatmap_pkg.sv
// Shared widths, point payload and FSM encoding for the heat-map column dispatch path.
package heatmap_pkg;

   localparam int unsigned N_COLS = 101;
   localparam int unsigned X_W    = 10;
   localparam int unsigned Y_W    = 10;
   localparam int unsigned VAL_W  = 8;
   localparam int unsigned CNT_W  = 8;

   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [VAL_W-1:0] val;
   } point_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/point_fifo.sv
// Circular point queue with an occupancy counter; the caller never pushes when full or pops when empty.
module point_fifo
   import heatmap_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  point_t                       din,
   output point_t                       head,
   output logic [$clog2(FIFO_DEPTH):0]  occupancy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = AW + 1;

   point_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         occupancy <= occupancy + OW'(push) - OW'(pop);
      end
   end

   // Storage is not reset; only entries below occupancy are ever read.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/heat_dispatch_scheduler.sv
// Drains queued heat points into one-hot column write requests, with ack handshake,
// level-ack release, timeout abandonment and out-of-range drop accounting.
module heat_dispatch_scheduler
   import heatmap_pkg::X_W, heatmap_pkg::Y_W, heatmap_pkg::VAL_W, heatmap_pkg::CNT_W,
          heatmap_pkg::point_t, heatmap_pkg::state_t, heatmap_pkg::sat_inc,
          heatmap_pkg::ST_IDLE, heatmap_pkg::ST_ISSUE, heatmap_pkg::ST_WAIT_ACK,
          heatmap_pkg::ST_RELEASE;
#(
   parameter int unsigned N_COLS      = heatmap_pkg::N_COLS,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pt_valid,
   output logic              pt_ready,
   input  logic [X_W-1:0]    pt_x,
   input  logic [Y_W-1:0]    pt_y,
   input  logic [VAL_W-1:0]  pt_val,
   output logic [N_COLS-1:0] col_select,
   output logic [Y_W-1:0]    row_select,
   output logic [VAL_W-1:0]  data_out,
   input  logic [N_COLS-1:0] return_sig,
   output logic              idle,
   output logic [CNT_W-1:0]  err_oob_count,
   output logic [CNT_W-1:0]  timeout_count
);

   localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

   state_t             state;
   point_t             head;
   point_t             in_pt;
   logic [OCC_W-1:0]   occupancy;
   logic [OCC_W-1:0]   occ_next;
   logic [N_COLS-1:0]  sel_mask;
   logic [CNT_W-1:0]   wait_cnt;
   logic push_c, pop_c, empty_c, head_oob_c, ack_c, tmo_c, rel_done_c, to_idle_c;

   function automatic logic [N_COLS-1:0] onehot(input logic [X_W-1:0] x);
      logic [N_COLS-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N_COLS; i++) m[i] = (32'(x) == i);
      return m;
   endfunction

   assign in_pt = '{x: pt_x, y: pt_y, val: pt_val};

   point_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_c),
      .pop       (pop_c),
      .din       (in_pt),
      .head      (head),
      .occupancy (occupancy)
   );

   assign empty_c    = (occupancy == '0);
   assign head_oob_c = (32'(head.x) >= N_COLS);
   assign push_c     = pt_valid && pt_ready;
   assign pop_c      = (state == ST_IDLE) && !empty_c;
   assign occ_next   = occupancy + OCC_W'(push_c) - OCC_W'(pop_c);

   // sel_mask keeps the issued column through RELEASE so its level ack can be watched falling.
   assign ack_c      = |(return_sig & sel_mask);
   assign tmo_c      = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));
   assign rel_done_c = !ack_c || tmo_c;
   assign to_idle_c  = ((state == ST_IDLE) && (empty_c || head_oob_c)) ||
                       ((state == ST_RELEASE) && rel_done_c);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= ST_IDLE;
         col_select    <= '0;
         sel_mask      <= '0;
         row_select    <= '0;
         data_out      <= '0;
         wait_cnt      <= '0;
         err_oob_count <= '0;
         timeout_count <= '0;
         pt_ready      <= 1'b0;
         idle          <= 1'b0;
      end else begin
         pt_ready <= (occ_next != OCC_W'(FIFO_DEPTH));
         idle     <= to_idle_c && (occ_next == '0);
         case (state)
            ST_IDLE: begin
               // Select is loaded on the pop edge so it is visible while in ISSUE.
               if (!empty_c) begin
                  if (head_oob_c) begin
                     err_oob_count <= sat_inc(err_oob_count);
                  end else begin
                     col_select <= onehot(head.x);
                     sel_mask   <= onehot(head.x);
                     row_select <= head.y;
                     data_out   <= head.val;
                     wait_cnt   <= '0;
                     state      <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               state    <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (ack_c || tmo_c) begin
                  col_select <= '0;
                  wait_cnt   <= '0;
                  state      <= ST_RELEASE;
                  if (!ack_c) timeout_count <= sat_inc(timeout_count);
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (rel_done_c) state <= ST_IDLE;
               else            wait_cnt <= wait_cnt + CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_heat_dispatch_scheduler.sv
// Randomized scoreboard bench: stimulus queues expected deliveries, a monitor checks each column write.
module tb_heat_dispatch_scheduler;

   localparam int NC    = 101;
   localparam int DEPTH = 8;
   localparam int TMO   = 255;
   localparam int NEVER = -1;

   typedef struct {
      int x;
      int y;
      int v;
      int dur;
      int t;
      bit lat;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          pt_valid;
   logic          pt_ready;
   logic [9:0]    pt_x;
   logic [9:0]    pt_y;
   logic [7:0]    pt_val;
   logic [NC-1:0] col_select;
   logic [NC-1:0] return_sig;
   logic [NC-1:0] resp_sig;
   logic [NC-1:0] stale_sig;
   logic [9:0]    row_select;
   logic [7:0]    data_out;
   logic          idle;
   logic [7:0]    err_oob_count;
   logic [7:0]    timeout_count;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   m_oob = 0;
   int   m_tmo = 0;
   bit   mon_active = 0;
   exp_t exp_q[$];
   int   plan_q[$];

   assign return_sig = resp_sig | stale_sig;

   heat_dispatch_scheduler #(.N_COLS(NC), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
      .clock         (clock),
      .reset         (reset),
      .pt_valid      (pt_valid),
      .pt_ready      (pt_ready),
      .pt_x          (pt_x),
      .pt_y          (pt_y),
      .pt_val        (pt_val),
      .col_select    (col_select),
      .row_select    (row_select),
      .data_out      (data_out),
      .return_sig    (return_sig),
      .idle          (idle),
      .err_oob_count (err_oob_count),
      .timeout_count (timeout_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int col_idx(input logic [NC-1:0] s);
      for (int i = 0; i < NC; i++) if (s[i]) return i;
      return -1;
   endfunction

   function automatic int sat8(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Offer one point, record what the column side should see, return the cycle after acceptance.
   task automatic push_pt(input int x, input int y, input int v, input int plan, input bit stale);
      int   n;
      exp_t e;
      n = 0;
      pt_x = 10'(x); pt_y = 10'(y); pt_val = 8'(v); pt_valid = 1'b1;
      while (!pt_ready && n < 1000) begin
         @(posedge clock); #1; n++;
      end
      if (n >= 1000) begin
         chk("push_wait", pt_ready, 1);
         pt_valid = 1'b0;
         return;
      end
      if (x >= NC) begin
         m_oob = sat8(m_oob);
      end else begin
         e.x = x; e.y = y; e.v = v; e.t = cyc; e.lat = idle;
         if (stale)              e.dur = 2;
         else if (plan == NEVER) begin e.dur = TMO; m_tmo = sat8(m_tmo); end
         else                    e.dur = plan + 1;
         exp_q.push_back(e);
         plan_q.push_back(plan);
      end
      @(posedge clock); #1;
      pt_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(idle && exp_q.size() == 0 && !mon_active) && n < 3000) begin
         @(posedge clock); #1; n++;
      end
      chk({tag, "_idle"}, idle, 1);
      chk({tag, "_pending"}, exp_q.size(), 0);
      chk({tag, "_oob_count"}, err_oob_count, m_oob);
      chk({tag, "_timeout_count"}, timeout_count, m_tmo);
   endtask

   // Column model: raise the ack d cycles after select, hold until select drops, then release.
   initial begin
      logic [NC-1:0] prev;
      int d, c, n;
      resp_sig = '0;
      prev = '0;
      forever begin
         @(negedge clock);
         if (reset !== 1'b1) begin
            prev = '0;
         end else if (prev == '0 && col_select != '0 && plan_q.size() > 0) begin
            d = plan_q.pop_front();
            c = col_idx(col_select);
            if (d != NEVER) begin
               repeat (d) @(negedge clock);
               resp_sig[c] = 1'b1;
               n = 0;
               while (col_select[c] && n < 400) begin
                  @(negedge clock); n++;
               end
               repeat ($urandom_range(0, 3)) @(negedge clock);
               resp_sig[c] = 1'b0;
            end
            prev = col_select;
         end else begin
            prev = col_select;
         end
      end
   end

   // Monitor: every new select is matched against the head of the expected queue.
   initial begin
      logic [NC-1:0] mon_prev;
      logic [NC-1:0] cur_sel;
      exp_t cur;
      int   dur;
      int   last_col;
      bit   hold_bad;
      mon_prev = '0;
      last_col = -1;
      dur = 0;
      hold_bad = 0;
      cur_sel = '0;
      forever begin
         @(negedge clock);
         if (reset !== 1'b1) begin
            mon_active = 0;
            mon_prev   = '0;
            last_col   = -1;
         end else begin
            if (mon_prev == '0 && col_select != '0) begin
               chk("onehot", $countones(col_select), 1);
               if (last_col >= 0) chk("prev_return_low", return_sig[last_col], 0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_issue_col", col_idx(col_select), -1);
               end else begin
                  cur = exp_q.pop_front();
                  chk("col", col_idx(col_select), cur.x);
                  chk("row", row_select, cur.y);
                  chk("data", data_out, cur.v);
                  if (cur.lat) chk("latency", cyc - cur.t, 2);
                  mon_active = 1;
                  dur = 1;
                  hold_bad = 0;
                  cur_sel = col_select;
               end
            end else if (mon_active) begin
               if (col_select != '0) begin
                  dur++;
                  if (col_select !== cur_sel || row_select !== 10'(cur.y) || data_out !== 8'(cur.v))
                     hold_bad = 1;
               end else begin
                  chk("select_cycles", dur, cur.dur);
                  chk("hold", hold_bad, 0);
                  mon_active = 0;
                  last_col = cur.x;
               end
            end
            mon_prev = col_select;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before cycle 50000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_val = '0; stale_sig = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_col_select", col_select != '0, 0);
      chk("rst_row_select", row_select, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_pt_ready", pt_ready, 0);
      chk("rst_idle", idle, 0);
      chk("rst_oob_count", err_oob_count, 0);
      chk("rst_timeout_count", timeout_count, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_pt_ready", pt_ready, 1);
      chk("post_rst_idle", idle, 1);

      // Single point, ack three cycles after select.
      push_pt(5, 17, 8'h7F, 3, 0);
      wait_idle("single");
      chk("single_return_low_at_idle", return_sig[5], 0);

      // Out-of-range column is dropped, next point issues normally.
      push_pt(150, 1, 2, 1, 0);
      push_pt(7, 33, 8'hA5, 2, 0);
      wait_idle("oob");

      // Column never acks: abandoned after the timeout.
      push_pt(3, 44, 8'h55, NEVER, 0);
      wait_idle("timeout");

      // Stale level ack on column 9: counted once, next point waits for the fall.
      stale_sig[9] = 1'b1;
      push_pt(9, 100, 8'h12, NEVER, 1);
      push_pt(20, 200, 8'h34, 2, 0);
      repeat (25) begin @(posedge clock); #1; end
      stale_sig[9] = 1'b0;
      wait_idle("stale");

      // Burst against a slow first ack: backpressure after 8 queued plus one in flight.
      for (int i = 0; i < 10; i++) begin
         push_pt(40 + i, i * 7, (i * 13) & 255, (i == 0) ? 60 : int'($urandom_range(1, 6)), 0);
         if (i == 7) chk("burst_ready_at_8", pt_ready, 1);
         if (i == 8) chk("burst_full_at_9", pt_ready, 0);
      end
      wait_idle("burst");

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         int x;
         int plan;
         x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(NC, 1023)) : int'($urandom_range(0, NC - 1));
         plan = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(1, 6));
         push_pt(x, int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), plan, 0);
         repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      end
      wait_idle("random");

      // Reset while waiting for an ack with points queued behind it.
      push_pt(30, 5, 8'h0F, NEVER, 0);
      for (int i = 0; i < 4; i++) push_pt(31 + i, i, i, 2, 0);
      repeat (5) begin @(posedge clock); #1; end
      reset = 1'b0;
      exp_q.delete();
      plan_q.delete();
      m_oob = 0;
      m_tmo = 0;
      @(posedge clock); #1;
      chk("mid_rst_col_select", col_select != '0, 0);
      chk("mid_rst_pt_ready", pt_ready, 0);
      chk("mid_rst_idle", idle, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("mid_rel_pt_ready", pt_ready, 1);
      chk("mid_rel_idle", idle, 1);
      repeat (30) begin @(posedge clock); #1; end
      chk("flushed_idle", idle, 1);
      chk("flushed_col_select", col_select != '0, 0);
      push_pt(12, 77, 8'h66, 2, 0);
      wait_idle("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/heat_dispatch_scheduler.md
HEAT_DISPATCH_SCHEDULER -- requirements
Module: heat_dispatch_scheduler

Interface
REQ-001 Parameter N_COLS, default 101, number of column M10K blocks (one col_select/return_sig bit each).
REQ-002 Parameter FIFO_DEPTH, default 8 (power of 2), depth of the point queue.
REQ-003 Parameter ACK_TIMEOUT, default 255, maximum WAIT_ACK cycles before a point is abandoned.
REQ-004 clock  in  1  single system clock (CLOCK_50 domain); all logic is clocked on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset: 0 = reset, sampled on the rising edge of clock.
REQ-006 pt_valid  in  1  point offered by the mailbox reader.
REQ-007 pt_ready  out  1  queue can accept a point this cycle.
REQ-008 pt_x / pt_y / pt_val  in  10/10/8  column index, row index, signed heat value.
REQ-009 col_select  out  N_COLS  one-hot write request to column block pt_x.
REQ-010 row_select / data_out  out  10/8  row index and value for the selected column.
REQ-011 return_sig  in  N_COLS  per-column write-acknowledge level.
REQ-012 idle  out  1  queue empty and FSM in IDLE; mailbox reader may clear its HPS flag only when high.
REQ-013 err_oob_count / timeout_count  out  8/8  saturating counters of dropped points.

Function
REQ-014 Accept a point on the cycle where pt_valid && pt_ready; pt_ready = !full, computed from registered occupancy.
REQ-015 Simultaneous push and pop when full is not allowed (pt_ready low); when neither full nor empty, push and pop in the same cycle leave occupancy unchanged.
REQ-016 FSM states: IDLE, ISSUE, WAIT_ACK, RELEASE.
REQ-017 IDLE: if the queue is non-empty, pop the head into holding registers and enter ISSUE; otherwise stay in IDLE.
REQ-018 Head with x >= N_COLS is popped and discarded, err_oob_count increments (saturating at 255), and the FSM stays in IDLE.
REQ-019 ISSUE: drive col_select = one-hot(x), row_select = y, data_out = val (registered); next state WAIT_ACK.
REQ-020 WAIT_ACK: hold the outputs; on return_sig[x]==1, clear col_select and enter RELEASE; increment the 8-bit wait counter each cycle.
REQ-021 When the wait counter reaches ACK_TIMEOUT without an ack, clear col_select, increment timeout_count (saturating), and enter RELEASE.
REQ-022 RELEASE: wait until return_sig[x]==0 (or ACK_TIMEOUT more cycles), then enter IDLE; this prevents double-counting a level ack.
REQ-023 At most one col_select bit is high in any cycle; return_sig bits other than x are ignored.
REQ-024 Latency: a point pushed into an empty queue with the FSM in IDLE at cycle t has col_select asserted from cycle t+2.
REQ-025 idle is registered: high only when occupancy==0 and state==IDLE.
REQ-026 Pointer wrap-around uses log2(FIFO_DEPTH) bits plus an occupancy counter of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 When reset==0: state=IDLE, occupancy=0, pointers=0, col_select=0, row_select=0, data_out=0, both counters=0, pt_ready=0, idle=0.
REQ-028 One cycle after reset is released, pt_ready=1 and idle=1.
REQ-029 Reset asserted in WAIT_ACK drops col_select on the next edge and discards all queued points.

Structure
REQ-030 A shared package (heatmap_pkg) holds N_COLS, the coordinate widths (X_W=10, Y_W=10, VAL_W=8), and the state encodings.
REQ-031 The queue is a sub-module, point_fifo (storage width X_W+Y_W+VAL_W, parameter FIFO_DEPTH); the FSM, counters and the one-hot decode stay in heat_dispatch_scheduler.

Verification
REQ-032 Single point x=5, y=17, val=0x7F into an empty queue, with return_sig[5] raised 3 cycles after select -> col_select==1<<5 from t+2, row_select==17, data_out==0x7F, idle returns high after return_sig[5] falls.
REQ-033 Burst of 10 points with the column never acking until the fifth point -> pt_ready low after 8 queued (+1 in flight), all 10 delivered in order, no point lost.
REQ-034 Point x=150 -> no col_select activity, err_oob_count==1, next valid point issued normally.
REQ-035 Column 3 never acks -> col_select[3] held for exactly 255 cycles, then cleared, timeout_count==1, FSM back in IDLE.
REQ-036 reset driven to 0 during WAIT_ACK with 4 points queued -> col_select==0 after one edge, occupancy 0, idle==1 one cycle after release.
REQ-037 Stale return_sig[9] held high while x=9 is issued -> one delivery counted; RELEASE waits for the fall before the next point is issued.
